// File: rtl/dmem_responder.sv
// Single-port data-memory responder: accepts one M-stage load/store at a time
// and answers LATENCY cycles later. Define DMEM_MISALIGN_CHK_EN to flag and squash misaligned accesses.
module dmem_responder #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memReqM,
   input  logic        memWriteM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] writeDataM,
   output logic [31:0] readDataM,
   output logic        memStallM,
   output logic        memErrM
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  mis_q, mis_d;
   logic [31:0]           rdata_q;
   logic                  enter_done;
   logic                  req_mis;
   logic                  unused_addr_bits;

   logic [31:0] mem_q [DEPTH];

`ifdef DMEM_MISALIGN_CHK_EN
   assign req_mis = (ALUOutM[1:0] != 2'b00);
`else
   assign req_mis = 1'b0;
`endif

   // Upper bits alias the array; low bits only matter for the misalign check.
   assign unused_addr_bits = ^{ALUOutM[31:DEPTH_LOG2+2], ALUOutM[1:0]};

   // The *_d operand signals carry the access completing this edge: the live
   // inputs when LATENCY=1 accepts and finishes at once, the captured copy otherwise.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      mis_d      = mis_q;
      enter_done = 1'b0;
      memStallM  = 1'b0;
      case (state_q)
         IDLE: begin
            if (memReqM && !rst) begin
               memStallM = 1'b1;
               addr_d    = ALUOutM[DEPTH_LOG2+1:2];
               we_d      = memWriteM;
               wdata_d   = writeDataM;
               mis_d     = req_mis;
               cnt_d     = CNT_INIT;
               if (LATENCY == 1) begin
                  state_d    = DONE;
                  enter_done = 1'b1;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            memStallM = 1'b1;
            cnt_d     = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d    = DONE;
               enter_done = 1'b1;
            end
         end
         // DONE never accepts, so a still-asserted request is not served twice.
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (enter_done && !we_d) begin
            rdata_q <= mis_d ? 32'd0 : mem_q[addr_d];
         end
      end
   end

   // Operand capture needs no reset: it is only consumed after an acceptance.
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
   end

   always_ff @(posedge clk) begin
      if (enter_done && we_d && !mis_d) begin
         mem_q[addr_d] <= wdata_d;
      end
   end

   assign readDataM = rdata_q;

`ifdef DMEM_MISALIGN_CHK_EN
   logic err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= enter_done && mis_d;
      end
   end

   assign memErrM = err_q;
`else
   assign memErrM = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for most traffic,
// LATENCY=1 instance for the held-request / back-to-back case.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, we;
   logic [31:0] addr, wd, rd;
   logic        stall, err;
   logic        req1, we1;
   logic [31:0] addr1, wd1, rd1;
   logic        stall1, err1;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .memReqM(req), .memWriteM(we), .ALUOutM(addr),
      .writeDataM(wd), .readDataM(rd), .memStallM(stall), .memErrM(err)
   );

   dmem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .memReqM(req1), .memWriteM(we1), .ALUOutM(addr1),
      .writeDataM(wd1), .readDataM(rd1), .memStallM(stall1), .memErrM(err1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one access on dut starting just after a falling edge; returns the
   // DONE-cycle outputs, memErrM one cycle later and the number of stall cycles.
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd_o, output logic err_o,
                         output logic err_after, output int stalls);
      req    = 1'b1;
      we     = w;
      addr   = a;
      wd     = d;
      stalls = 0;
      #1;
      while (stall && stalls < 40) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      rd_o  = rd;
      err_o = err;
      req   = 1'b0;
      @(negedge clk);
      #1;
      err_after = err;
      $display("txn %s addr=0x%08h wdata=0x%08h rdata=0x%08h err=%0b stalls=%0d",
               w ? "ST" : "LD", a, d, rd_o, err_o, stalls);
   endtask

   logic [31:0] r;
   logic        e, ea;
   int          s;

   initial begin
      rst = 1'b1; req = 1'b1; we = 1'b0; addr = '0; wd = '0;
      req1 = 1'b1; we1 = 1'b0; addr1 = '0; wd1 = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_rdata", rd, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_stall_l1", {31'd0, stall1}, 32'd0);
      req = 1'b0; req1 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("idle_stall", {31'd0, stall}, 32'd0);

      // LATENCY=1: request held high through DONE is served once, then re-accepted.
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h8; wd1 = 32'hCAFEF00D;
      #1;
      chk("l1_accept_st", {31'd0, stall1}, 32'd1);
      @(negedge clk); #1;
      chk("l1_done_st", {31'd0, stall1}, 32'd0);
      chk("l1_st_rd_kept", rd1, 32'd0);
      we1 = 1'b0;
      #1;
      chk("l1_done_ignores", {31'd0, stall1}, 32'd0);
      @(negedge clk); #1;
      chk("l1_reaccept", {31'd0, stall1}, 32'd1);
      @(negedge clk); #1;
      chk("l1_done_ld", {31'd0, stall1}, 32'd0);
      chk("l1_ld_data", rd1, 32'hCAFEF00D);
      $display("txn L1 ST/LD addr=0x00000008 rdata=0x%08h", rd1);
      req1 = 1'b0;
      @(negedge clk); #1;
      chk("l1_idle", {31'd0, stall1}, 32'd0);
      chk("l1_hold", rd1, 32'hCAFEF00D);

      // Store then load 0x10.
      access(1'b1, 32'h10, 32'hDEADBEEF, r, e, ea, s);
      chk("st10_stalls", s, 32'd2);
      chk("st10_rd_kept", r, 32'd0);
      chk("st10_err", {31'd0, e}, 32'd0);
      access(1'b0, 32'h10, 32'h0, r, e, ea, s);
      chk("ld10_stalls", s, 32'd2);
      chk("ld10_data", r, 32'hDEADBEEF);

      // Aliasing: 0x404 maps onto the same word as 0x004.
      access(1'b1, 32'h004, 32'h11111111, r, e, ea, s);
      access(1'b1, 32'h404, 32'h22222222, r, e, ea, s);
      chk("st404_rd_kept", r, 32'hDEADBEEF);
      access(1'b0, 32'h004, 32'h0, r, e, ea, s);
      chk("alias_ld", r, 32'h22222222);

      // Reset in the middle of a store must leave the old word intact.
      access(1'b1, 32'h20, 32'hA5A5A5A5, r, e, ea, s);
      req = 1'b1; we = 1'b1; addr = 32'h20; wd = 32'h12345678;
      #1;
      chk("abort_accept", {31'd0, stall}, 32'd1);
      @(negedge clk); #1;
      chk("abort_wait", {31'd0, stall}, 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_stall", {31'd0, stall}, 32'd0);
      chk("abort_rd", rd, 32'd0);
      req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("abort_idle", {31'd0, stall}, 32'd0);
      chk("abort_no_done", rd, 32'd0);
      access(1'b0, 32'h20, 32'h0, r, e, ea, s);
      chk("abort_ld20", r, 32'hA5A5A5A5);

      // Misaligned accesses.
      access(1'b1, 32'h22, 32'h99999999, r, e, ea, s);
`ifdef DMEM_MISALIGN_CHK_EN
      chk("mis_st_err", {31'd0, e}, 32'd1);
      chk("mis_st_err_pulse", {31'd0, ea}, 32'd0);
      access(1'b0, 32'h20, 32'h0, r, e, ea, s);
      chk("mis_st_suppressed", r, 32'hA5A5A5A5);
      access(1'b0, 32'h23, 32'h0, r, e, ea, s);
      chk("mis_ld_data", r, 32'd0);
      chk("mis_ld_err", {31'd0, e}, 32'd1);
`else
      chk("mis_st_err", {31'd0, e}, 32'd0);
      access(1'b0, 32'h20, 32'h0, r, e, ea, s);
      chk("mis_st_written", r, 32'h99999999);
      access(1'b0, 32'h23, 32'h0, r, e, ea, s);
      chk("mis_ld_data", r, 32'h99999999);
      chk("mis_ld_err", {31'd0, e}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
